nibble_serial_adder: RTL and testbench
======================================

// Module: nibble_serial_adder
// PURPOSE
//  Multi-cycle WIDTH-bit adder that sequences one 4-bit bitAdd_4 slice.
//  The slice adds one nibble per clock, LSB nibble first, and chains the carry through a register.
//  Sits directly upstream of bitAdd_4: it feeds the slice operands and carry-in, and consumes out/co.
//  Trades latency for area in wide datapaths. Valid/ready handshake on both sides.
// PARAMETERS
//  WIDTH    16    operand/sum width in bits; must be a multiple of 4, >= 8
//  NIBBLES  WIDTH/4  derived localparam, not overridable; number of slice passes
// PORTS
//  clk        in   1      single clock, all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operands a/b/ci valid
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   WIDTH  operand A (unsigned / two's complement)
//  b          in   WIDTH  operand B
//  ci         in   1      carry-in into nibble 0
//  out_valid  out  1      sum/co/ovf valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  a + b + ci, modulo 2^WIDTH
//  co         out  1      carry out of bit WIDTH-1
//  ovf        out  1      signed overflow: a[MSB]==b[MSB] && sum[MSB]!=a[MSB]
// BEHAVIOUR
//  Reset (rst high at edge):
//   - State goes to IDLE; nibble index = 0; carry reg = 0.
//   - sum=0, co=0, ovf=0, out_valid=0; operand regs cleared.
//   - in_ready=1 from the first cycle after the reset edge.
//   - rst has priority over every other event, in any state (mid-RUN or DONE); the in-flight result is discarded.
//  FSM states IDLE -> RUN -> DONE -> IDLE:
//   - IDLE: in_ready=1, out_valid=0. If in_valid at the edge: register a, b, ci into operand/carry regs, idx=0, go to RUN.
//   - RUN: in_ready=0. Each cycle, the slice adds a_reg[4*idx+:4] + b_reg[4*idx+:4] + carry_reg.
//     - Slice out is written to sum_reg[4*idx+:4]; carry_reg <= slice co.
//     - idx increments each cycle; at idx==NIBBLES-1 the final co is captured, ovf is computed, and the FSM goes to DONE.
//   - DONE: out_valid=1; sum/co/ovf held stable.
//     - If out_ready at the edge, go to IDLE (out_valid drops the next cycle).
//     - Without out_ready, the FSM holds indefinitely.
//  Latency: the accept edge is cycle 0; out_valid is high after edge NIBBLES (4 for WIDTH=16).
//  Throughput: one operation per NIBBLES+2 cycles minimum.
//   - There is no accept in DONE, even when out_ready is high in the same cycle.
//  Input handling:
//   - a/b/ci/in_valid are ignored outside IDLE; operands are sampled only at the accept edge.
//   - Changes to a/b after accept do not affect the result.
//  out_ready outside DONE is ignored.
//  sum/co/ovf keep their last result after the DONE->IDLE transition until overwritten by the next operation.
//   - The sum nibbles are overwritten progressively during RUN; consumers must qualify with out_valid.
//  Carry ripples through all nibbles, e.g. 0xFFFF+0+1 propagates over NIBBLES cycles.
//  No combinational path from in_valid to in_ready, or from out_ready to out_valid.
// TESTING (WIDTH=16)
//  1. rst high 2 cycles, then low -> sum=0, co=0, ovf=0, out_valid=0, in_ready=1.
//  2. a=0x0001, b=0x0001, ci=0 accepted -> out_valid high exactly 4 cycles later; sum=0x0002, co=0, ovf=0.
//  3. a=0xFFFF, b=0x0000, ci=1 -> sum=0x0000, co=1, ovf=0.
//     a=0x0F0F, b=0x00F1, ci=0 -> sum=0x1000, co=0 (inter-nibble carry).
//  4. a=0x7FFF, b=0x0001 -> sum=0x8000, co=0, ovf=1.
//     a=0x8000, b=0x8000 -> sum=0x0000, co=1, ovf=1.
//     a=0xFFFF, b=0xFFFF, ci=1 -> sum=0xFFFF, co=1, ovf=0.
//  5. Hold out_ready=0 for 5 cycles in DONE while toggling a/b/in_valid -> sum/co/ovf stable, in_ready=0.
//     Then pulse out_ready -> IDLE next cycle, in_ready=1.
//  6. Assert rst on the 2nd RUN cycle -> next cycle IDLE, all outputs 0.
//     A fresh 0x1234+0x4321, ci=0 then gives sum=0x5555, co=0.

Source files
------------

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
// The master side supplies operands and accepts results; the slave side is the adder.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;

    modport master (
        output in_valid, a, b, ci, out_ready,
        input  in_ready, out_valid, sum, co, ovf
    );

    modport slave (
        input  in_valid, a, b, ci, out_ready,
        output in_ready, out_valid, sum, co, ovf
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder built from one 4-bit slice, used once per clock, LSB nibble first.
// The carry between nibbles is held in a register; results come out on a valid/ready handshake.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    nibble_serial_adder_if.slave  bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = $clog2(NIBBLES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             co_reg;
    logic             ovf_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       slice;

    // Behaviour of the downstream 4-bit slice: {co, out} = x + y + c.
    function automatic logic [4:0] bit_add4(input logic [3:0] x, input logic [3:0] y,
                                            input logic c);
        return {1'b0, x} + {1'b0, y} + {4'b0000, c};
    endfunction

    always_comb begin
        a_nib = a_reg[4*idx +: 4];
        b_nib = b_reg[4*idx +: 4];
        slice = bit_add4(a_nib, b_nib, carry);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            carry         <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            sum_reg       <= '0;
            co_reg        <= 1'b0;
            ovf_reg       <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg        <= bus.a;
                        b_reg        <= bus.b;
                        carry        <= bus.ci;
                        idx          <= '0;
                        in_ready_reg <= 1'b0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[4*idx +: 4] <= slice[3:0];
                    carry               <= slice[4];
                    idx                 <= idx + 1'b1;
                    // Top nibble: its slice MSB is the final sum sign bit.
                    if (idx == IDX_W'(NIBBLES - 1)) begin
                        co_reg        <= slice[4];
                        ovf_reg       <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                         (slice[3] != a_reg[WIDTH-1]);
                        out_valid_reg <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.sum       = sum_reg;
    assign bus.co        = co_reg;
    assign bus.ovf       = ovf_reg;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): vector table, random
// vectors against an arithmetic model, DONE hold, and mid-operation reset.
module tb_nibble_serial_adder;
    localparam int WIDTH = 16;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             ci;
        logic [WIDTH-1:0] sum;
        logic             co;
        logic             ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    vec_t sb[$];

    nibble_serial_adder_if #(.WIDTH(WIDTH)) bus();

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic ci);
        vec_t v;
        logic [WIDTH:0] full;
        full  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
        v.a   = a;
        v.b   = b;
        v.ci  = ci;
        v.sum = full[WIDTH-1:0];
        v.co  = full[WIDTH];
        v.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        return v;
    endfunction

    // Runs one operation starting at a negedge with the DUT idle; hold = DONE cycles without out_ready.
    task automatic do_op(input vec_t v, input int hold);
        vec_t e;
        int   lat;
        logic [WIDTH-1:0] s_sum;
        logic s_co, s_ovf;
        bus.a        = v.a;
        bus.b        = v.b;
        bus.ci       = v.ci;
        bus.in_valid = 1'b1;
        sb.push_back(v);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = ~v.a;
        bus.b        = ~v.b;
        check("in_ready_run", 32'(bus.in_ready), 32'd0);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 32'd4);
        e = sb.pop_front();
        check("sum", 32'(bus.sum), 32'(e.sum));
        check("co", 32'(bus.co), 32'(e.co));
        check("ovf", 32'(bus.ovf), 32'(e.ovf));
        s_sum = bus.sum;
        s_co  = bus.co;
        s_ovf = bus.ovf;
        for (int i = 0; i < hold; i++) begin
            bus.a        = WIDTH'($urandom);
            bus.b        = WIDTH'($urandom);
            bus.in_valid = ~bus.in_valid;
            @(negedge clk);
            check("hold_sum", 32'(bus.sum), 32'(s_sum));
            check("hold_co_ovf", 32'({bus.co, bus.ovf}), 32'({s_co, s_ovf}));
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
        end
        // in_valid stays high across the release edge: DONE must not accept it.
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("release_out_valid", 32'(bus.out_valid), 32'd0);
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
        tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[7] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.ci        = 1'b0;
        bus.out_ready = 1'b0;

        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_co_ovf", 32'({bus.co, bus.ovf}), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 8; i++) do_op(tbl[i], (i == 3) ? 5 : 0);

        for (int i = 0; i < 6; i++)
            do_op(model(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1))), 0);

        // Reset during the second RUN cycle discards the operation.
        bus.a        = 16'h1111;
        bus.b        = 16'h2222;
        bus.ci       = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_sum", 32'(bus.sum), 32'd0);
        check("midrst_co_ovf", 32'({bus.co, bus.ovf}), 32'd0);
        @(negedge clk);
        check("midrst_no_result", 32'(bus.out_valid), 32'd0);
        do_op('{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0}, 0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
